// File: rtl/gecko_pkg.sv
// Shared definitions for the gecko keystream host side: default key width,
// byte width and the one-hot state encoding of keystream_xor.
package gecko_pkg;

    localparam int KEY_LENGTH_DEFAULT = 56;
    localparam int BYTE_W             = 8;

    localparam logic [2:0] ST_SAMPLE  = 3'b001;
    localparam logic [2:0] ST_KEYLOAD = 3'b010;
    localparam logic [2:0] ST_RUN     = 3'b100;

    typedef enum logic [2:0] {
        SAMPLE  = ST_SAMPLE,
        KEYLOAD = ST_KEYLOAD,
        RUN     = ST_RUN
    } state_e;

endpackage

// File: rtl/keystream_clken_div.sv
// Clock-enable divider for the keystream generator: a 0..DIV-1 counter that
// only advances while en is high; clken is high in the cycle the counter wraps.
module keystream_clken_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic clken
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With DIV=1 the counter sits at 0, so clken is high whenever enabled.
    assign clken = en && (cnt_q == LAST);

endmodule

// File: rtl/keystream_xor.sv
// Host-side partner of the gecko generator: loads the key serially, then XORs
// each input byte with one fresh keystream byte. KEYSTREAM_XOR_COUNT_EN builds byte_count.
module keystream_xor
    import gecko_pkg::*;
#(
    parameter int KEY_LENGTH = KEY_LENGTH_DEFAULT,
    parameter int CLKEN_DIV  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_LENGTH-1:0] key_in,
    output logic                  ks_clken,
    output logic                  ks_key,
    output logic                  ks_next,
    input  logic                  ks_ready,
    input  logic [BYTE_W-1:0]     ks_dout,
    input  logic [BYTE_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [BYTE_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  key_zero,
    output logic [31:0]           byte_count
);

    localparam int               CNT_W    = $clog2(KEY_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_LENGTH - 1);

    state_e                  state_q, state_d;
    logic [KEY_LENGTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    key_zero_q, key_zero_d;
    logic                    ks_used_q, ks_used_d;
    logic                    m_valid_q, m_valid_d;
    logic [BYTE_W-1:0]       m_data_q, m_data_d;
    logic                    consume;
    logic [BYTE_W-1:0]       ks_byte;

    keystream_clken_div #(
        .DIV (CLKEN_DIV)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q != SAMPLE),
        .clken (ks_clken)
    );

    // Handshakes: a byte moves on s_* when s_valid & s_ready, on m_* when
    // m_valid & m_ready. One input byte, one keystream byte and one output
    // slot are claimed together, and only on a generator-enabled cycle.
    assign consume = (state_q == RUN) && s_valid && ks_ready && !ks_used_q &&
                     (!m_valid_q || m_ready) && ks_clken;

    // A zero key means decryption is disabled: bytes pass through unchanged.
    assign ks_byte = key_zero_q ? '0 : ks_dout;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        key_zero_d = key_zero_q;
        case (state_q)
            SAMPLE: begin
                shreg_d    = key_in;
                key_zero_d = (key_in == '0);
                bit_cnt_d  = '0;
                state_d    = KEYLOAD;
            end
            KEYLOAD: begin
                if (ks_clken) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
            end
            default: state_d = SAMPLE;
        endcase
    end

    always_comb begin
        ks_used_d = ks_used_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (consume) begin
            ks_used_d = 1'b1;
            m_valid_d = 1'b1;
            m_data_d  = s_data ^ ks_byte;
        end else begin
            // The generator drops ready while it replaces the byte we took.
            if (!ks_ready) begin
                ks_used_d = 1'b0;
            end
            if (m_ready) begin
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SAMPLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            key_zero_q <= 1'b0;
            ks_used_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            key_zero_q <= key_zero_d;
            ks_used_q  <= ks_used_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
        end
    end

`ifdef KEYSTREAM_XOR_COUNT_EN
    logic [31:0] byte_count_q, byte_count_d;

    always_comb begin
        byte_count_d = byte_count_q;
        if (consume) begin
            byte_count_d = byte_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_count_q <= 32'd0;
        end else begin
            byte_count_q <= byte_count_d;
        end
    end

    assign byte_count = byte_count_q;
`else
    assign byte_count = 32'd0;
`endif

    assign ks_key   = shreg_q[KEY_LENGTH-1];
    assign ks_next  = consume;
    assign s_ready  = consume;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign key_zero = key_zero_q;

endmodule

// File: tb/tb_keystream_xor.sv
// Bench for keystream_xor: a DIV=1 instance driven through key load, streaming,
// stalls, zero key and mid-stream reset, plus a DIV=4 instance with its own monitor.
module tb_keystream_xor;
    import gecko_pkg::*;

    localparam int KL = 56;
`ifdef KEYSTREAM_XOR_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [KL-1:0] key_in;

    logic        ks_clken, ks_key, ks_next, ks_ready;
    logic [7:0]  ks_dout, s_data, m_data;
    logic        s_valid, s_ready, m_valid, m_ready, key_zero;
    logic [31:0] byte_count;

    logic        ks_clken_4, ks_key_4, ks_next_4, ks_ready_4;
    logic [7:0]  ks_dout_4, s_data_4, m_data_4;
    logic        s_valid_4, s_ready_4, m_valid_4, m_ready_4, key_zero_4;
    logic [31:0] byte_count_4;

    keystream_xor #(.KEY_LENGTH(KL), .CLKEN_DIV(1)) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .ks_clken(ks_clken), .ks_key(ks_key), .ks_next(ks_next),
        .ks_ready(ks_ready), .ks_dout(ks_dout),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .key_zero(key_zero), .byte_count(byte_count)
    );

    keystream_xor #(.KEY_LENGTH(KL), .CLKEN_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .key_in(key_in),
        .ks_clken(ks_clken_4), .ks_key(ks_key_4), .ks_next(ks_next_4),
        .ks_ready(ks_ready_4), .ks_dout(ks_dout_4),
        .s_data(s_data_4), .s_valid(s_valid_4), .s_ready(s_ready_4),
        .m_data(m_data_4), .m_valid(m_valid_4), .m_ready(m_ready_4),
        .key_zero(key_zero_4), .byte_count(byte_count_4)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] src_q[$];
    logic [7:0] ks_mem[$];
    logic [7:0] exp_q[$];
    logic [7:0] out_log[$];
    logic       kz_model;
    int         cnt_model;
    int         nxt_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic [KL-1:0] k);
        rst = 1'b1; key_in = k;
        s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        ks_ready = 1'b0; ks_dout = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", {ks_clken, ks_key, ks_next, s_ready, m_valid, key_zero}, 6'b0);
        check_eq("rst_m_data", m_data, 8'h00);
        check_eq("rst_byte_count", byte_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Watches the serial key, then lets one probe byte through on RUN entry.
    task automatic load_key(input logic [KL-1:0] k, input logic [7:0] pd, input logic [7:0] pk);
        int pulses = 0;
        int cyc = 0;
        int bad_sready = 0;
        logic [7:0] e;
        kz_model = (k == '0);
        cnt_model = 0;
        s_valid = 1'b1; s_data = pd; ks_ready = 1'b1; ks_dout = pk; m_ready = 1'b1;
        while (pulses < KL && cyc < 4 * KL) begin
            @(negedge clk);
            cyc++;
            if (s_ready) bad_sready++;
            if (ks_clken) begin
                pulses++;
                check_eq($sformatf("key_bit_p%0d", pulses), ks_key, k[KL-pulses]);
            end
        end
        check_eq("keyload_pulses", pulses, KL);
        check_eq("keyload_cycles", cyc, KL + 1);
        check_eq("keyload_s_ready_low", bad_sready, 0);
        check_eq("key_zero", key_zero, kz_model);
        @(negedge clk);
        check_eq("run_entry_accept", s_ready, 1'b1);
        check_eq("run_entry_next", ks_next, 1'b1);
        check_eq("key_after_load", ks_key, 1'b0);
        e = pd ^ (kz_model ? 8'h00 : pk);
        cnt_model = 1;
        @(posedge clk); #1;
        s_valid = 1'b0; ks_ready = 1'b0;
        @(negedge clk);
        check_eq("probe_m_valid", m_valid, 1'b1);
        check_eq("probe_m_data", m_data, e);
        @(posedge clk); #1;
    endtask

    // Streams src_q through the DUT against a keystream stub serving ks_mem
    // in order; the stub keeps showing a consumed byte for 0..2 cycles before
    // dropping ready, then presents the next byte.
    task automatic run_stream(input int stall_len, input bit rst_on_accept);
        logic acc, nxt, ohs, prev_stall, done;
        logic [7:0] prev_data;
        int stall_left = stall_len;
        int hold = 0, gap = 0, ks_pos = 0, cyc = 0;
        bit stale = 1'b0;
        done = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
        exp_q.delete();
        ks_ready = 1'b1; ks_dout = ks_mem[0]; s_valid = 1'b0; m_ready = 1'b1;
        while (!done && cyc < 2000) begin
            cyc++;
            @(negedge clk);
            acc = s_valid && s_ready;
            nxt = ks_next;
            ohs = m_valid && m_ready;
            if (prev_stall) begin
                check_eq("stall_valid_hold", m_valid, 1'b1);
                check_eq("stall_data_hold", m_data, prev_data);
            end
            if (m_valid && !m_ready) check_eq("s_ready_low_when_blocked", s_ready, 1'b0);
            check_eq("next_with_accept", nxt, acc);
            if (acc) begin
                check_eq("accept_ks_fresh", stale, 1'b0);
                check_eq("accept_ks_ready", ks_ready, 1'b1);
                exp_q.push_back(src_q[0] ^ (kz_model ? 8'h00 : ks_mem[ks_pos]));
                cnt_model++;
            end
            if (nxt) nxt_cnt++;
            if (ohs) begin
                if (exp_q.size() == 0) check_eq("unexpected_output", 1'b1, 1'b0);
                else check_eq("m_data", m_data, exp_q.pop_front());
                out_log.push_back(m_data);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (rst_on_accept && acc) begin
                rst = 1'b1;
                return;
            end
            @(posedge clk); #1;
            if (acc) begin
                void'(src_q.pop_front());
                s_valid = 1'b0;
            end
            if (nxt) begin
                ks_pos++;
                stale = 1'b1;
                hold = $urandom_range(0, 2);
            end
            if (stale && ks_ready) begin
                if (hold == 0) begin
                    ks_ready = 1'b0;
                    gap = $urandom_range(1, 2);
                end else hold--;
            end else if (!ks_ready) begin
                gap--;
                if (gap == 0) begin
                    ks_ready = 1'b1;
                    ks_dout = ks_mem[ks_pos];
                    stale = 1'b0;
                end
            end
            if (!s_valid && src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                s_valid = 1'b1;
                s_data = src_q[0];
            end
            if (stall_left > 0 && m_valid) begin
                m_ready = 1'b0;
                stall_left--;
            end else m_ready = ($urandom_range(0, 3) != 0);
            done = (src_q.size() == 0) && (exp_q.size() == 0);
        end
        check_eq("stream_done", done, 1'b1);
        s_valid = 1'b0; ks_ready = 1'b0;
        @(negedge clk);
        check_eq("byte_count", byte_count, COUNT_EN ? 32'(cnt_model) : 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic fill(input int n);
        src_q.delete(); ks_mem.delete();
        for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
        for (int i = 0; i <= n; i++) ks_mem.push_back(8'($urandom));
    endtask

    // ---------------- DIV=4 instance: stub and monitor ----------------
    logic n4;
    initial begin
        s_valid_4 = 1'b1; m_ready_4 = 1'b1; s_data_4 = 8'h3C;
        ks_dout_4 = 8'h55; ks_ready_4 = 1'b1;
        forever begin
            @(negedge clk);
            n4 = ks_next_4;
            @(posedge clk); #1;
            ks_ready_4 = !n4;
        end
    end

    int c4, p4, last4;
    bit first4_done;
    logic [KL-1:0] key4;
    always @(negedge clk) begin
        if (rst) begin
            c4 = 0; p4 = 0; last4 = -1; first4_done = 1'b0;
        end else begin
            if (c4 == 0) key4 = key_in;
            if (ks_clken_4) begin
                p4++;
                if (last4 >= 0) check_eq("d4_clken_period", c4 - last4, 4);
                else check_eq("d4_first_pulse_cycle", c4, 4);
                last4 = c4;
                if (p4 <= KL) check_eq("d4_key_bit", ks_key_4, key4[KL-p4]);
            end
            if (ks_next_4) check_eq("d4_next_on_clken", ks_clken_4, 1'b1);
            if (s_ready_4 && !first4_done) begin
                first4_done = 1'b1;
                check_eq("d4_first_accept_cycle", c4, 4 * (KL + 1));
            end
            if (m_valid_4 && first4_done)
                check_eq("d4_m_data", m_data_4, (key4 == '0) ? 8'h3C : 8'h69);
            c4++;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [KL-1:0] k1, k2;
        rst = 1'b1;
        nxt_cnt = 0;

        do_reset(56'h80_0000_0000_0001);
        load_key(56'h80_0000_0000_0001, 8'($urandom), 8'($urandom));

        src_q = '{8'h0F, 8'hFF};
        ks_mem = '{8'hA5, 8'h3C, 8'h00};
        out_log.delete(); nxt_cnt = 0;
        run_stream(0, 1'b0);
        check_eq("single_out_count", out_log.size(), 2);
        check_eq("single_byte0", out_log[0], 8'hAA);
        check_eq("single_byte1", out_log[1], 8'hC3);
        check_eq("single_next_pulses", nxt_cnt, 2);

        fill(4);
        run_stream(6, 1'b0);
        fill(40);
        run_stream(3, 1'b0);

        do_reset('0);
        load_key('0, 8'h5A, 8'h77);
        fill(8);
        run_stream(2, 1'b0);

        k1 = {24'($urandom), 32'($urandom)};
        k2 = {24'($urandom), 32'($urandom)} | 56'h1;
        do_reset(k1);
        load_key(k1, 8'($urandom), 8'($urandom));
        fill(10);
        run_stream(0, 1'b1);
        @(posedge clk); #1;
        key_in = k2; s_valid = 1'b0; ks_ready = 1'b0;
        @(negedge clk);
        check_eq("midrst_m_valid", m_valid, 1'b0);
        check_eq("midrst_s_ready", s_ready, 1'b0);
        check_eq("midrst_byte_count", byte_count, 32'd0);
        check_eq("midrst_m_data", m_data, 8'h00);
        check_eq("midrst_clken", ks_clken, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        load_key(k2, 8'($urandom), 8'($urandom));
        repeat (250) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
